axi_stream_downsizer: RTL and testbench

AXI_STREAM_DOWNSIZER -- requirements
Module: axi_stream_downsizer

---
 rtl/axi_stream_downsizer_if.sv | 25 ++
 rtl/axi_stream_downsizer.sv | 71 +++++++
 tb/tb_axi_stream_downsizer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_downsizer_if.sv
// Handshake bundle for the downsizer: upstream word side (*_in) and downstream beat side (*_out).
// slave = the downsizer's view, master = the environment driving it.
interface axi_stream_downsizer_if #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = $clog2(IN_WIDTH / OUT_WIDTH) + 1
);
  logic                 vld_in;
  logic [IN_WIDTH-1:0]  data_in;
  logic [CNT_WIDTH-1:0] beats_in;
  logic                 rdy_in;
  logic                 vld_out;
  logic [OUT_WIDTH-1:0] data_out;
  logic                 last_out;
  logic                 rdy_out;

  modport slave (
    input  vld_in, data_in, beats_in, rdy_out,
    output rdy_in, vld_out, data_out, last_out
  );
  modport master (
    output vld_in, data_in, beats_in, rdy_out,
    input  rdy_in, vld_out, data_out, last_out
  );
endinterface

// File: rtl/axi_stream_downsizer.sv
// Splits one IN_WIDTH word into up to RATIO OUT_WIDTH beats, lane 0 first.
// A new word may load on the same edge the last beat leaves, so full words stream with no bubble.
module axi_stream_downsizer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int RATIO     = (OUT_WIDTH > 0) ? IN_WIDTH / OUT_WIDTH : 0,
  parameter int CNT_WIDTH = $clog2(RATIO) + 1
) (
  input logic                    clk,
  input logic                    rst,
  axi_stream_downsizer_if.slave  bus
);
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_WIDTH-1:0] RATIO_C = CNT_WIDTH'(RATIO);

  generate
    if (OUT_WIDTH <= 0 || (IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_cfg
      $error("axi_stream_downsizer: illegal IN_WIDTH/OUT_WIDTH/RATIO combination");
    end
  endgenerate

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                          state;
  logic [RATIO-1:0][OUT_WIDTH-1:0] hold;
  logic [IDX_W-1:0]                idx;
  logic [CNT_WIDTH-1:0]            n;

  logic                 in_fire, out_fire, last_nx;
  logic [IDX_W-1:0]     idx_nx;
  logic [CNT_WIDTH-1:0] eff;

  // Zero or oversized counts mean "whole word".
  assign eff      = (bus.beats_in == '0 || bus.beats_in > RATIO_C) ? RATIO_C : bus.beats_in;
  assign idx_nx   = idx + 1'b1;
  assign last_nx  = (CNT_WIDTH'(idx_nx) == n - 1'b1);
  assign bus.rdy_in = !rst && (state == EMPTY || (bus.vld_out && bus.last_out && bus.rdy_out));
  assign in_fire  = bus.vld_in && bus.rdy_in;
  assign out_fire = bus.vld_out && bus.rdy_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      hold         <= '0;
      idx          <= '0;
      n            <= '0;
      bus.vld_out  <= 1'b0;
      bus.last_out <= 1'b0;
      bus.data_out <= '0;
    end else if (in_fire) begin
      state        <= SEND;
      hold         <= bus.data_in;
      idx          <= '0;
      n            <= eff;
      bus.vld_out  <= 1'b1;
      bus.last_out <= (eff == CNT_WIDTH'(1));
      bus.data_out <= bus.data_in[OUT_WIDTH-1:0];
    end else if (out_fire) begin
      if (bus.last_out) begin
        // data_out keeps the last beat while idle
        state        <= EMPTY;
        bus.vld_out  <= 1'b0;
        bus.last_out <= 1'b0;
      end else begin
        idx          <= idx_nx;
        bus.data_out <= hold[idx_nx];
        bus.last_out <= last_nx;
      end
    end
  end
endmodule

// File: tb/tb_axi_stream_downsizer.sv
// Scoreboarded bench for axi_stream_downsizer: accepted words push expected beats, accepted beats pop them.
module tb_axi_stream_downsizer;
  localparam int IW = 64;
  localparam int OW = 16;
  localparam int CW = 3;
  localparam logic [IW-1:0] WORD_A = 64'h4444_3333_2222_1111;
  localparam logic [IW-1:0] WORD_B = 64'h8888_7777_6666_5555;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    failures = 0;
  beat_t sb[$];
  beat_t exp_b;

  axi_stream_downsizer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();
  axi_stream_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .RATIO(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int eff_beats(input logic [CW-1:0] b);
    return (b == 0 || b > 4) ? 4 : int'(b);
  endfunction

  // Scoreboard: pop on each accepted beat, push expected lanes on each accepted word.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.vld_out && bus.rdy_out) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_beat: got data=%h last=%b, required no beat", bus.data_out, bus.last_out);
        end else begin
          exp_b = sb.pop_front();
          if ({bus.data_out, bus.last_out} !== exp_b) begin
            failures++;
            $display("FAIL sb_beat: got data=%h last=%b, required data=%h last=%b",
                     bus.data_out, bus.last_out, exp_b.data, exp_b.last);
          end
        end
      end
      if (bus.vld_in && bus.rdy_in) begin
        for (int i = 0; i < eff_beats(bus.beats_in); i++)
          sb.push_back(beat_t'{data: bus.data_in[i*OW +: OW], last: (i == eff_beats(bus.beats_in) - 1)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and return 1 time unit after the edge that accepted it; vld_in is left high.
  task automatic offer(input logic [IW-1:0] d, input logic [CW-1:0] b);
    bus.vld_in = 1'b1;
    bus.data_in = d;
    bus.beats_in = b;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.rdy_in) break;
    end
    checks++;
    if (bus.rdy_in !== 1'b1) begin
      failures++;
      $display("FAIL offer_timeout: rdy_in=%b, required 1", bus.rdy_in);
    end
    tick();
  endtask

  task automatic drain(input string name);
    bus.vld_in = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.vld_out) break;
    end
    checks++;
    if (sb.size() != 0 || bus.vld_out !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: pending=%0d vld_out=%b, required 0 and 0", name, sb.size(), bus.vld_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.vld_in = 1'b0; bus.data_in = '0; bus.beats_in = '0; bus.rdy_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.vld_out, bus.last_out, bus.rdy_in} !== 3'b000 || bus.data_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: vld=%b last=%b rdy_in=%b data=%h, required 0 0 0 0000",
               bus.vld_out, bus.last_out, bus.rdy_in, bus.data_out);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    checks++;
    if (bus.rdy_in !== 1'b1 || bus.vld_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rdy_in=%b vld_out=%b, required 1 0", bus.rdy_in, bus.vld_out);
    end
  endtask

  task automatic test_full_word();
    logic [OW-1:0] lanes [4];
    lanes[0] = 16'h1111; lanes[1] = 16'h2222; lanes[2] = 16'h3333; lanes[3] = 16'h4444;
    offer(WORD_A, 3'd4);
    bus.vld_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.vld_out !== 1'b1 || bus.data_out !== lanes[i] || bus.last_out !== (i == 3)) begin
        failures++;
        $display("FAIL full_word_beat%0d: vld=%b data=%h last=%b, required 1 %h %b",
                 i, bus.vld_out, bus.data_out, bus.last_out, lanes[i], (i == 3));
      end
    end
    drain("full_word");
  endtask

  task automatic test_back_to_back();
    offer(WORD_A, 3'd4);
    bus.data_in = WORD_B;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (bus.vld_out !== 1'b1 || bus.rdy_in !== (c == 4 || c == 8)) begin
        failures++;
        $display("FAIL b2b_cycle%0d: vld_out=%b rdy_in=%b, required 1 %b", c, bus.vld_out, bus.rdy_in, (c == 4 || c == 8));
      end
      tick();
      if (c == 4) bus.vld_in = 1'b0;
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    offer(WORD_A, 3'd4);
    bus.vld_in = 1'b0;
    tick();
    bus.rdy_out = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.vld_out !== 1'b1 || bus.data_out !== 16'h2222 || bus.last_out !== 1'b0 || bus.rdy_in !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold%0d: vld=%b data=%h last=%b rdy_in=%b, required 1 2222 0 0",
                 c, bus.vld_out, bus.data_out, bus.last_out, bus.rdy_in);
      end
      tick();
    end
    bus.rdy_out = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_partial_clamp();
    offer(WORD_A, 3'd2);
    bus.vld_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.last_out !== 1'b1 || bus.data_out !== 16'h2222) begin
      failures++;
      $display("FAIL partial2_last: data=%h last=%b, required 2222 1", bus.data_out, bus.last_out);
    end
    drain("partial2");
    offer(WORD_B, 3'd0);
    drain("beats0");
    offer(WORD_A, 3'd7);
    drain("beats7");
  endtask

  task automatic test_reset_mid_word();
    offer(WORD_A, 3'd4);
    bus.vld_in = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.vld_out, bus.last_out, bus.rdy_in} !== 3'b000 || bus.data_out !== 16'h0) begin
      failures++;
      $display("FAIL midreset_outputs: vld=%b last=%b rdy_in=%b data=%h, required 0 0 0 0000",
               bus.vld_out, bus.last_out, bus.rdy_in, bus.data_out);
    end
    sb.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    checks++;
    if (bus.rdy_in !== 1'b1 || bus.vld_out !== 1'b0) begin
      failures++;
      $display("FAIL midreset_release: rdy_in=%b vld_out=%b, required 1 0", bus.rdy_in, bus.vld_out);
    end
    offer(WORD_B, 3'd4);
    checks++;
    if (bus.vld_out !== 1'b1 || bus.data_out !== 16'h5555) begin
      failures++;
      $display("FAIL midreset_restart: vld=%b data=%h, required 1 5555", bus.vld_out, bus.data_out);
    end
    drain("midreset");
  endtask

  task automatic test_single_beat();
    logic [OW-1:0] v;
    for (int k = 0; k < 4; k++) begin
      v = 16'hA0A0 + 16'(k);
      offer({48'h0, v}, 3'd1);
      checks++;
      if (bus.vld_out !== 1'b1 || bus.last_out !== 1'b1 || bus.data_out !== v) begin
        failures++;
        $display("FAIL single_beat%0d: vld=%b last=%b data=%h, required 1 1 %h",
                 k, bus.vld_out, bus.last_out, bus.data_out, v);
      end
    end
    drain("single");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_backpressure();
    test_partial_clamp();
    test_reset_mid_word();
    test_single_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
